// File: rtl/handshake_rr_arb_pkg.sv
// Shared types and constants for the packet-locking round-robin arbiter.
package handshake_rr_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 32;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/handshake_rr_arb_rr_pick.sv
// Combinational round-robin pick: first set req starting at prio, wrapping mod N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] prio,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(prio) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arb.sv
// N-to-1 valid/ready arbiter: round-robin between packets, grant locked to the
// owner until its last beat, single registered output stage at 1 beat/cycle.
module handshake_rr_arb
  import handshake_rr_arb_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  N     = DEF_N,
  localparam int IDW   = idw(N)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N-1:0]       valid_i,
  input  logic [N-1:0]       last_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [N-1:0]       ready_o,
  output logic               valid_o,
  output logic               last_o,
  output logic [IDW-1:0]     id_o,
  output logic [WIDTH-1:0]   data_o,
  input  logic               ready_i
);

  state_t         state;
  logic [IDW-1:0] prio, owner, src, gnt_idx;
  logic [N-1:0]   gnt;
  logic           any, can_load, load;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (valid_i),
    .prio    (prio),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign can_load = !valid_o || ready_i;
  assign src      = (state == LOCK) ? owner : gnt_idx;
  assign load     = |ready_o;

  // Gated by rstn so masters never see an accept during reset.
  always_comb begin
    ready_o = '0;
    if (rstn && can_load) begin
      if (state == ARB) begin
        if (any) ready_o = gnt;
      end else if (valid_i[owner]) begin
        ready_o[owner] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB;
      prio    <= '0;
      owner   <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      id_o    <= '0;
      data_o  <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      last_o  <= last_i[src];
      id_o    <= src;
      data_o  <= data_i[int'(src)*WIDTH +: WIDTH];
      if (last_i[src]) begin
        state <= ARB;
        prio  <= (int'(src) == N-1) ? '0 : src + 1'b1;
      end else if (state == ARB) begin
        state <= LOCK;
        owner <= src;
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_rr_arb.sv
// Directed self-checking bench for handshake_rr_arb (N=4, WIDTH=32).
module tb_handshake_rr_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   valid_i, last_i, ready_o;
  logic [N*W-1:0] data_i;
  logic           valid_o, last_o, ready_i;
  logic [1:0]     id_o;
  logic [W-1:0]   data_o;

  int checks = 0;
  int passes = 0;

  handshake_rr_arb #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .id_o    (id_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                         input logic l, input logic [W-1:0] d);
    chk({tag, ".valid"}, 64'(valid_o), 64'(v));
    if (v) begin
      chk({tag, ".id"},   64'(id_o),   64'(id));
      chk({tag, ".last"}, 64'(last_o), 64'(l));
      chk({tag, ".data"}, 64'(data_o), 64'(d));
    end
  endtask

  initial begin
    rstn    = 1'b0;
    valid_i = '0;
    last_i  = '0;
    ready_i = 1'b1;
    data_i  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0a00};
    #2;
    chk("rst.valid_o", 64'(valid_o), 64'd0);
    chk("rst.last_o",  64'(last_o),  64'd0);
    chk("rst.id_o",    64'(id_o),    64'd0);
    chk("rst.data_o",  64'(data_o),  64'd0);
    valid_i = 4'hF;
    #1;
    chk("rst.ready_o", 64'(ready_o), 64'd0);
    valid_i = '0;
    tick();
    rstn = 1'b1;
    tick();

    // Four single-beat requesters rotate 0,1,2,3,0 with no bubbles.
    valid_i = 4'hF; last_i = 4'hF;
    #1;
    chk("rr.ready0", 64'(ready_o), 64'b0001);
    tick(); chk_out("rr.b0", 1'b1, 2'd0, 1'b1, 32'h0000_0a00);
    chk("rr.ready1", 64'(ready_o), 64'b0010);
    tick(); chk_out("rr.b1", 1'b1, 2'd1, 1'b1, 32'h1111_0001);
    tick(); chk_out("rr.b2", 1'b1, 2'd2, 1'b1, 32'h2222_0002);
    tick(); chk_out("rr.b3", 1'b1, 2'd3, 1'b1, 32'h3333_0003);
    chk("rr.wrap_ready", 64'(ready_o), 64'b0001);
    tick(); chk_out("rr.b4", 1'b1, 2'd0, 1'b1, 32'h0000_0a00);
    valid_i = '0;
    tick(); chk("rr.drain", 64'(valid_o), 64'd0);

    // Lone single-beat request from 2 (prio is 1 here).
    data_i[2*W +: W] = 32'hA5A5_0002;
    valid_i = 4'b0100; last_i = 4'b0100;
    #1;
    chk("one.ready", 64'(ready_o), 64'b0100);
    tick(); chk_out("one.out", 1'b1, 2'd2, 1'b1, 32'hA5A5_0002);
    valid_i = '0;
    tick(); chk("one.drop", 64'(valid_o), 64'd0);

    // 3-beat packet from 1 while 2 waits (prio is 3: search 3,0,1).
    valid_i = 4'b0110; last_i = 4'b0100;
    #1;
    chk("pkt.ready_a", 64'(ready_o), 64'b0010);
    tick(); chk_out("pkt.b1", 1'b1, 2'd1, 1'b0, 32'h1111_0001);
    chk("pkt.ready_b", 64'(ready_o), 64'b0010);
    tick(); chk_out("pkt.b2", 1'b1, 2'd1, 1'b0, 32'h1111_0001);
    last_i = 4'b0110;
    #1;
    chk("pkt.ready_c", 64'(ready_o), 64'b0010);
    tick(); chk_out("pkt.b3", 1'b1, 2'd1, 1'b1, 32'h1111_0001);
    valid_i = 4'b0100;
    #1;
    chk("pkt.ready_d", 64'(ready_o), 64'b0100);
    tick(); chk_out("pkt.next", 1'b1, 2'd2, 1'b1, 32'hA5A5_0002);
    valid_i = '0;
    tick(); chk("pkt.drain", 64'(valid_o), 64'd0);

    // Backpressure: output holds while ready_i is low (prio is 3).
    valid_i = 4'b0001; last_i = 4'b0011;
    tick(); chk_out("bp.first", 1'b1, 2'd0, 1'b1, 32'h0000_0a00);
    ready_i = 1'b0;
    valid_i = 4'b0011;
    data_i[0 +: W] = 32'h0000_0bbb;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.ready", 64'(ready_o), 64'd0);
      tick(); chk_out("bp.hold", 1'b1, 2'd0, 1'b1, 32'h0000_0a00);
    end
    ready_i = 1'b1;
    #1;
    chk("bp.release_ready", 64'(ready_o), 64'b0010);
    tick(); chk_out("bp.next", 1'b1, 2'd1, 1'b1, 32'h1111_0001);
    valid_i = '0;
    tick(); chk("bp.drain", 64'(valid_o), 64'd0);

    // Owner 3 idles mid-packet; 0 must wait for 3's last beat (prio is 2).
    valid_i = 4'b1001; last_i = 4'b0001;
    #1;
    chk("lk.ready_a", 64'(ready_o), 64'b1000);
    tick(); chk_out("lk.b1", 1'b1, 2'd3, 1'b0, 32'h3333_0003);
    valid_i = 4'b0001;
    #1;
    chk("lk.gap1", 64'(ready_o), 64'd0);
    tick(); chk("lk.gap1_valid", 64'(valid_o), 64'd0);
    chk("lk.gap2", 64'(ready_o), 64'd0);
    tick();
    valid_i = 4'b1001; last_i = 4'b1001;
    #1;
    chk("lk.ready_b", 64'(ready_o), 64'b1000);
    tick(); chk_out("lk.last", 1'b1, 2'd3, 1'b1, 32'h3333_0003);
    chk("lk.ready_c", 64'(ready_o), 64'b0001);
    tick(); chk_out("lk.zero", 1'b1, 2'd0, 1'b1, 32'h0000_0bbb);
    valid_i = '0;
    tick();

    // Reset in the middle of a packet from 1 (prio is 1).
    valid_i = 4'b0010; last_i = 4'b0000;
    tick(); chk_out("rl.b1", 1'b1, 2'd1, 1'b0, 32'h1111_0001);
    rstn = 1'b0;
    valid_i = 4'b0101; last_i = 4'b0101;
    #1;
    chk("rl.valid_o", 64'(valid_o), 64'd0);
    chk("rl.id_o",    64'(id_o),    64'd0);
    chk("rl.ready",   64'(ready_o), 64'd0);
    #2;
    rstn = 1'b1;
    #1;
    chk("rl.ready_after", 64'(ready_o), 64'b0001);
    tick(); chk_out("rl.first", 1'b1, 2'd0, 1'b1, 32'h0000_0bbb);
    tick(); chk_out("rl.second", 1'b1, 2'd2, 1'b1, 32'hA5A5_0002);
    valid_i = '0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
